aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
- Upstream feeder for the Encryption core.
- Accepts a byte stream over a valid/ready handshake and packs 16 bytes big-endian into a 128-bit plain_text block.
- Samples the cipher key, raises start to the core, holds both stable until the core's valid_flag, then re-opens for the next block.
- Supports a short final block via in_last, with zero padding.

Parameters:
- BLK_BYTES, 16, bytes per AES block. Fixed by AES; only the value 16 is legal.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  qualifies in_data as the final byte of a message.
- in_ready  output  1  packer accepts a byte this cycle.
- key_in  input  128  cipher key, bit 0 = MSB; sampled at launch.
- enc_valid_flag  input  1  valid_flag returned by Encryption.
- start  output  1  to Encryption start.
- key  output  128  to Encryption key, [0:127].
- plain_text  output  128  to Encryption plain_text, [0:127].
- busy  output  1  a block is in flight in the core.
- blk_count  output  CNT_W  number of completed blocks.
- pad_flag  output  1  the in-flight block was zero-padded.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Outputs: start=0, key=0, plain_text=0, busy=0, blk_count=0, pad_flag=0.
  - State = FILL, byte index = 0, in_ready=1 on the first cycle after reset release.
  - Reset mid-block discards the partial block; the Encryption core is reset from the same reset_n.
- Handshake: a byte transfers when in_valid & in_ready at a clock edge. in_ready = (state==FILL).
- Packing:
  - The byte with index i (0..15) is written to buffer bits [8i : 8i+7].
  - The first byte lands in plain_text[0:7] (MSB).
  - Unfilled bytes are 0.
  - The buffer is internal; plain_text is updated only at launch.
- FILL -> LAUNCH when either:
  - a transfer occurs with index==15, or
  - a transfer occurs with in_last=1 at any index.
  - If in_last=1 at index<15, pad_flag is set to 1 for that block; otherwise pad_flag=0.
- LAUNCH, one cycle:
  - plain_text <= buffer (including the byte just accepted).
  - key <= key_in.
  - start <= 1, busy <= 1.
  - Index clears to 0; the buffer clears to 0.
  - in_ready=0.
- Latency: start is visible the cycle after the final byte's transfer edge.
- WAIT:
  - start, key and plain_text are held stable; in_ready=0.
  - On enc_valid_flag=1: start <= 0, busy <= 0, blk_count <= blk_count+1, state <= FILL.
  - blk_count wraps modulo 2^CNT_W.
  - in_ready=1 in the following cycle.
- enc_valid_flag is ignored in FILL and in LAUNCH.
  - A stale flag from the previous block, still high during LAUNCH, must not complete the new block.
  - WAIT therefore also requires that enc_valid_flag has been seen low at least once since launch.
- in_last with zero bytes pending is impossible: in_last always qualifies a transferred byte.
- in_valid=0 in FILL holds all state; no timeout.
- Asserting in_last on the 16th byte: the block is launched normally and pad_flag=0.

Decomposition:
- Package aes_pkg holds:
  - the state enum typedef (FILL, LAUNCH, WAIT);
  - localparam BLK_BYTES=16;
  - the byte-index width (4).
- One natural sub-module, aes_byte_shifter: 16x8 buffer with indexed write and clear. The FSM and handshake stay in the top module.

Test Plan:
- Full block: stream 00 00 01 01 03 03 07 07 0f 0f 1f 1f 3f 3f 7f 7f, key_in=0 -> cycle after the 16th transfer: plain_text=0000_0101_0303_0707_0f0f_1f1f_3f3f_7f7f, start=1, in_ready=0. With the Encryption core attached, enc_data=c7d1_2419_489e_3b62_33a2_c5a7_f456_3172 and blk_count=1.
- Back-to-back blocks: stream 12 34 ab cd 56 78 ef ef 91 0a 1f e2 89 3f 7a bb, key_in=4500_6000_00ff_ab00_cb00_bddd_0056_6644 -> core output 98e8_f827_e554_4bdf_58d4_2211_47dc_2b28; blk_count=2; in_ready=0 throughout WAIT.
- Short block: bytes aa bb cc with in_last on cc -> plain_text=aabbcc00_00000000_00000000_00000000, pad_flag=1, start=1.
- Backpressure: in_valid held high during WAIT -> no byte lost or duplicated; the next block's byte 0 is accepted the cycle after enc_valid_flag.
- Reset mid-fill: after 7 bytes, pulse reset_n low for 1 cycle -> all outputs 0, index 0; the next 16 bytes form a clean block.
- Stale flag: enc_valid_flag forced high through LAUNCH -> block not completed until the flag drops and rises again; blk_count unchanged until then.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block packer: FSM states, block size
// and byte-index width.
package aes_pkg;

  localparam int BLK_BYTES = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// 16x8 block buffer with indexed byte write and synchronous clear.
// blk_o shows the contents including the write of this cycle.
module aes_byte_shifter
  import aes_pkg::*;
(
  input  logic                   clock,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [7:0]             wr_data_i,
  output logic [8*BLK_BYTES-1:0] blk_o
);

  logic [BLK_BYTES-1:0][7:0] buf_q;
  logic [BLK_BYTES-1:0][7:0] buf_d;

  always_comb begin
    buf_d = buf_q;
    if (wr_en_i) begin
      buf_d[wr_idx_i] = wr_data_i;
    end
  end

  // Byte 0 is the most significant byte of the block.
  always_comb begin
    blk_o = '0;
    for (int i = 0; i < BLK_BYTES; i++) begin
      blk_o[8*BLK_BYTES-1-8*i -: 8] = buf_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (clr_i) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit blocks and hands each one, with the key,
// to the Encryption core; holds them until the core reports completion.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [127:0]     key_in,
  input  logic             enc_valid_flag,
  output logic             start,
  output logic [127:0]     key,
  output logic [127:0]     plain_text,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             pad_flag
);

  // Bit 127 here is the core's bit 0 (MSB) for key and plain_text.
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [127:0]     plain_text_q, key_q;
  logic             start_q, busy_q, pad_q, seen_low_q;
  logic [CNT_W-1:0] blk_count_q;

  logic             accept, launch, complete, last_byte;
  logic [127:0]     blk_next;

  assign last_byte = (idx_q == IDX_W'(BLK_BYTES - 1));
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    launch   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || last_byte)) begin
          launch  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // A flag left high from the previous block must drop before it counts.
        if (enc_valid_flag && seen_low_q) begin
          complete = 1'b1;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  aes_byte_shifter u_shifter (
    .clock     (clock),
    .clr_i     (launch | ~reset_n),
    .wr_en_i   (accept),
    .wr_idx_i  (idx_q),
    .wr_data_i (in_data),
    .blk_o     (blk_next)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx_q        <= '0;
      plain_text_q <= '0;
      key_q        <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      pad_q        <= 1'b0;
      seen_low_q   <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      if (accept) begin
        idx_q <= launch ? '0 : idx_q + IDX_W'(1);
      end
      if (launch) begin
        plain_text_q <= blk_next;
        key_q        <= key_in;
        start_q      <= 1'b1;
        busy_q       <= 1'b1;
        pad_q        <= in_last & ~last_byte;
        seen_low_q   <= 1'b0;
      end else if (state_q != FILL && !enc_valid_flag) begin
        seen_low_q <= 1'b1;
      end
      if (complete) begin
        start_q     <= 1'b0;
        busy_q      <= 1'b0;
        blk_count_q <= blk_count_q + CNT_W'(1);
      end
    end
  end

  assign start      = start_q;
  assign key        = key_q;
  assign plain_text = plain_text_q;
  assign busy       = busy_q;
  assign blk_count  = blk_count_q;
  assign pad_flag   = pad_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: a queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_aes_block_packer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [127:0] key_in = '0;
  logic         enc_valid_flag = 1'b0;
  logic         start;
  logic [127:0] key;
  logic [127:0] plain_text;
  logic         busy;
  logic [15:0]  blk_count;
  logic         pad_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int done_cyc = 0;

  aes_block_packer #(.CNT_W(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .key_in         (key_in),
    .enc_valid_flag (enc_valid_flag),
    .start          (start),
    .key            (key),
    .plain_text     (plain_text),
    .busy           (busy),
    .blk_count      (blk_count),
    .pad_flag       (pad_flag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: bytes collect in a queue until the block is full or
  // marked last; the packer is then busy until a fresh completion flag.
  logic [7:0]   q[$];
  logic [127:0] m_pt = '0, m_key = '0;
  bit           m_start = 0, m_busy = 0, m_pad = 0, m_low = 0, live = 0;
  int           m_age = 0;
  logic [15:0]  m_cnt = '0;

  always @(posedge clock) begin
    if (!reset_n) begin
      q.delete();
      m_pt = '0; m_key = '0; m_start = 0; m_busy = 0; m_pad = 0; m_cnt = '0;
      live = 1;
    end else if (!m_busy) begin
      if (in_valid) begin
        q.push_back(in_data);
        if (in_last || q.size() == 16) begin
          m_pt = '0;
          foreach (q[i]) m_pt[127-8*i -: 8] = q[i];
          m_key = key_in;
          m_pad = (q.size() < 16);
          m_start = 1; m_busy = 1; m_age = 0; m_low = 0;
          q.delete();
        end
      end
    end else begin
      if (m_age > 0 && enc_valid_flag && m_low) begin
        m_start = 0; m_busy = 0; m_cnt = m_cnt + 16'd1;
      end
      if (!enc_valid_flag) m_low = 1;
      m_age++;
    end
  end

  always @(negedge clock) begin
    if (live) begin
      chk("in_ready",   128'(in_ready),   128'(!m_busy));
      chk("start",      128'(start),      128'(m_start));
      chk("busy",       128'(busy),       128'(m_busy));
      chk("pad_flag",   128'(pad_flag),   128'(m_pad));
      chk("blk_count",  128'(blk_count),  128'(m_cnt));
      chk("plain_text", plain_text,       m_pt);
      chk("key",        key,              m_key);
    end
  end

  task automatic send(input logic [7:0] b, input bit last);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1; in_data = b; in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clock);
    #1;
    last_acc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic respond(input int dly);
    int n = 0;
    while (!busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL respond_timeout busy=%0b required=1", busy);
    end
    repeat (dly) @(negedge clock);
    enc_valid_flag = 1'b1;
    @(posedge clock);
    #1;
    enc_valid_flag = 1'b0;
    done_cyc = cyc;
  endtask

  logic [7:0] blk_a [16] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h07, 8'h07,
                             8'h0f, 8'h0f, 8'h1f, 8'h1f, 8'h3f, 8'h3f, 8'h7f, 8'h7f};
  logic [7:0] blk_b [16] = '{8'h12, 8'h34, 8'hab, 8'hcd, 8'h56, 8'h78, 8'hef, 8'hef,
                             8'h91, 8'h0a, 8'h1f, 8'he2, 8'h89, 8'h3f, 8'h7a, 8'hbb};

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clock);
    chk("rst_start",  128'(start),     128'd0);
    chk("rst_busy",   128'(busy),      128'd0);
    chk("rst_count",  128'(blk_count), 128'd0);
    chk("rst_pt",     plain_text,      128'd0);
    chk("rst_key",    key,             128'd0);
    chk("rst_ready",  128'(in_ready),  128'd1);
    reset_n = 1'b1;

    // Full block, zero key
    for (int i = 0; i < 16; i++) send(blk_a[i], 1'b0);
    chk("a_pt",    plain_text,     128'h0000_0101_0303_0707_0f0f_1f1f_3f3f_7f7f);
    chk("a_start", 128'(start),    128'd1);
    chk("a_ready", 128'(in_ready), 128'd0);
    chk("a_pad",   128'(pad_flag), 128'd0);
    respond(3);
    chk("a_count", 128'(blk_count), 128'd1);
    chk("a_busy",  128'(busy),      128'd0);

    // Back-to-back block, then a short block pushed during WAIT
    key_in = 128'h4500_6000_00ff_ab00_cb00_bddd_0056_6644;
    fork
      begin
        for (int i = 0; i < 16; i++) send(blk_b[i], 1'b0);
        chk("b_pt",  plain_text, 128'h1234_abcd_5678_efef_910a_1fe2_893f_7abb);
        chk("b_key", key,        128'h4500_6000_00ff_ab00_cb00_bddd_0056_6644);
        key_in = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;
        send(8'haa, 1'b0);
        chk("bp_accept_cycle", 128'(last_acc), 128'(done_cyc + 1));
        chk("b_count", 128'(blk_count), 128'd2);
        send(8'hbb, 1'b0);
        send(8'hcc, 1'b1);
        chk("c_pt",    plain_text,     128'haabbcc00_00000000_00000000_00000000);
        chk("c_pad",   128'(pad_flag), 128'd1);
        chk("c_start", 128'(start),    128'd1);
        chk("c_key",   key,            128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d);
      end
      begin
        respond(5);
        respond(4);
      end
    join
    chk("c_count", 128'(blk_count), 128'd3);

    // Reset in the middle of a fill
    for (int i = 0; i < 7; i++) send(8'h55, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("mr_count", 128'(blk_count), 128'd0);
    chk("mr_pt",    plain_text,      128'd0);
    chk("mr_start", 128'(start),     128'd0);
    chk("mr_ready", 128'(in_ready),  128'd1);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("d_pt",  plain_text,     128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f);
    chk("d_pad", 128'(pad_flag), 128'd0);
    respond(2);
    chk("d_count", 128'(blk_count), 128'd1);

    // Stale completion flag held through launch; last also on the 16th byte
    key_in = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    for (int i = 0; i < 15; i++) send(8'hf0 + 8'(i), 1'b0);
    enc_valid_flag = 1'b1;
    send(8'hff, 1'b1);
    repeat (4) @(negedge clock);
    chk("e_busy_held",  128'(busy),      128'd1);
    chk("e_count_held", 128'(blk_count), 128'd1);
    chk("e_pt",         plain_text,      128'hf0f1_f2f3_f4f5_f6f7_f8f9_fafb_fcfd_feff);
    chk("e_pad",        128'(pad_flag),  128'd0);
    enc_valid_flag = 1'b0;
    @(negedge clock);
    enc_valid_flag = 1'b1;
    @(posedge clock);
    #1;
    enc_valid_flag = 1'b0;
    chk("e_busy_done",  128'(busy),      128'd0);
    chk("e_count_done", 128'(blk_count), 128'd2);
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
